sr_latch_arbiter: RTL and testbench

SR_LATCH_ARBITER -- requirements
Module: sr_latch_arbiter

---
 rtl/sr_latch_arbiter.sv | 151 +++++++++++++++
 tb/tb_sr_latch_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sr_latch_arbiter: round-robin owner of one shared clocked SR latch |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module sr_latch_arbiter #(
  parameter int NREQ = 4,
  parameter int HOLD = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] op,
  input  logic            q_in,
  input  logic            err_clr,
  output logic [NREQ-1:0] gnt,
  output logic            s,
  output logic            r,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_CNT_W = $clog2(HOLD + 1);
  localparam logic [c_PTR_W:0]   c_NREQ     = (c_PTR_W+1)'(NREQ);
  localparam logic [c_PTR_W-1:0] c_LAST     = c_PTR_W'(NREQ - 1);
  localparam logic [NREQ-1:0]    c_GNT_ONE  = NREQ'(1);
  localparam logic [c_CNT_W-1:0] c_HOLD     = c_CNT_W'(HOLD);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_RELEASE = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  state_t             r_state;
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_op;
  logic               r_armed;
  logic [NREQ-1:0]    r_gnt;
  logic               r_s;
  logic               r_r;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic               w_found;
  logic [c_PTR_W-1:0] w_win;
  logic [c_PTR_W:0]   w_sum;
  logic [c_PTR_W-1:0] w_next_ptr;
  logic               w_win_op;

  // Round-robin search: first asserted request at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_ptr} + (c_PTR_W+1)'(i);
      if (w_sum >= c_NREQ) begin
        w_sum = w_sum - c_NREQ;
      end
      if (!w_found && req[w_sum[c_PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[c_PTR_W-1:0];
      end
    end
  end

  assign w_next_ptr = (w_win == c_LAST) ? '0 : (w_win + c_PTR_W'(1));
  assign w_win_op   = op[w_win];

  // r_armed delays the first grant after reset release by one edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_armed <= 1'b0;
      r_gnt   <= '0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_gnt   <= '0;
      r_done  <= 1'b0;
      if (err_clr) begin
        r_err <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (r_armed && w_found) begin
            r_state <= S_DRIVE;
            r_op    <= w_win_op;
            r_ptr   <= w_next_ptr;
            r_gnt   <= c_GNT_ONE << w_win;
            r_s     <= w_win_op;
            r_r     <= ~w_win_op;
            r_cnt   <= c_HOLD;
            r_busy  <= 1'b1;
          end
        end
        S_DRIVE: begin
          if (r_cnt == c_CNT_ONE) begin
            r_state <= S_RELEASE;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        S_RELEASE: begin
          // q_in has settled for a full guard cycle; flag and done appear together.
          r_state <= S_CHECK;
          r_done  <= 1'b1;
          if (!err_clr && (q_in != r_op)) begin
            r_err <= 1'b1;
          end
        end
        S_CHECK: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_s     <= 1'b0;
          r_r     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = r_gnt;
  assign s    = r_s;
  assign r    = r_r;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_arbiter.sv
`default_nettype none
// Bench for sr_latch_arbiter: directed scenarios plus random request mixes
// checked against a transaction-level round-robin model.
module tb_sr_latch_arbiter;

  localparam int NREQ = 4;
  localparam int HOLD = 2;

  logic            clk;
  logic            nrst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] op;
  logic            q_in;
  logic            err_clr;
  logic [NREQ-1:0] gnt;
  logic            s;
  logic            r;
  logic            busy;
  logic            done;
  logic            err;

  logic            q_lat = 1'b0;
  logic            force0;
  int              n_cmp;
  int              n_err;
  int              m_ptr;
  logic            m_err;
  logic [NREQ-1:0] last_gnt;
  logic [NREQ-1:0] fair_exp [5];

  sr_latch_arbiter #(.NREQ(NREQ), .HOLD(HOLD)) u_dut (
    .clk     (clk),
    .nrst    (nrst),
    .req     (req),
    .op      (op),
    .q_in    (q_in),
    .err_clr (err_clr),
    .gnt     (gnt),
    .s       (s),
    .r       (r),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural clocked SR latch; force0 models a stuck-low latch output.
  always @(posedge clk) begin
    if (s) q_lat <= 1'b1;
    else if (r) q_lat <= 1'b0;
  end
  assign q_in = force0 ? 1'b0 : q_lat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    chk("s_r_exclusive", 32'(s & r), 32'd0);
  endtask

  function automatic int rr(input logic [NREQ-1:0] m, input int p);
    for (int i = 0; i < NREQ; i++) begin
      int k;
      k = (p + i) % NREQ;
      if (((m >> k) & NREQ'(1)) != '0) return k;
    end
    return -1;
  endfunction

  // One complete operation starting from an IDLE cycle with req already driven.
  task automatic do_op(input int pre, input bit reissue, input bit clr_rel, input bit scramble);
    int w;
    logic o;
    logic [NREQ-1:0] exp_g;
    repeat (pre) begin
      cyc();
      chk("pre_gnt", 32'(gnt), 32'd0);
    end
    w = rr(req, m_ptr);
    if (w < 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL no_request: observed none expected a pending request");
      return;
    end
    o = |((op >> w) & NREQ'(1));
    exp_g = NREQ'(1) << w;
    cyc();
    last_gnt = gnt;
    chk("gnt", 32'(gnt), 32'(exp_g));
    chk("s_drive", 32'(s), 32'(o));
    chk("r_drive", 32'(r), 32'(!o));
    chk("busy_drive", 32'(busy), 32'd1);
    chk("done_drive", 32'(done), 32'd0);
    chk("err_hold", 32'(err), 32'(m_err));
    m_ptr = (w + 1) % NREQ;
    if (!reissue) req = req & ~(NREQ'(1) << w);
    for (int j = 1; j < HOLD; j++) begin
      cyc();
      chk("gnt_once", 32'(gnt), 32'd0);
      chk("s_hold", 32'(s), 32'(o));
      chk("r_hold", 32'(r), 32'(!o));
    end
    cyc();
    chk("s_release", 32'(s), 32'd0);
    chk("r_release", 32'(r), 32'd0);
    chk("busy_release", 32'(busy), 32'd1);
    chk("done_release", 32'(done), 32'd0);
    if (scramble) op = NREQ'($urandom);
    if (clr_rel) err_clr = 1'b1;
    cyc();
    if (clr_rel) begin
      err_clr = 1'b0;
      m_err = 1'b0;
    end else if (force0 && o) begin
      m_err = 1'b1;
    end
    chk("done_check", 32'(done), 32'd1);
    chk("err_check", 32'(err), 32'(m_err));
    chk("busy_check", 32'(busy), 32'd1);
    cyc();
    chk("done_idle", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("err_idle", 32'(err), 32'(m_err));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; m_ptr = 0; m_err = 1'b0; force0 = 1'b0;
    nrst = 1'b0; req = '0; op = '0; err_clr = 1'b0; last_gnt = '0;
    fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    repeat (3) cyc();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_s", 32'(s), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    nrst = 1'b1;
    repeat (2) begin
      cyc();
      chk("idle_gnt", 32'(gnt), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Set and reset requests at once: served one after the other.
    req = 4'b0011; op = 4'b0001;
    do_op(0, 1'b0, 1'b0, 1'b0);
    chk("conflict_first", 32'(last_gnt), 32'b0001);
    do_op(0, 1'b0, 1'b0, 1'b0);
    chk("conflict_second", 32'(last_gnt), 32'b0010);

    // Single set.
    req = 4'b0001; op = 4'b0001;
    do_op(0, 1'b0, 1'b0, 1'b0);
    chk("single_gnt", 32'(last_gnt), 32'b0001);
    chk("single_q", 32'(q_lat), 32'd1);

    // Bring pointer back to 0, then all four requesting continuously.
    req = 4'b1000; op = 4'b0000;
    do_op(0, 1'b0, 1'b0, 1'b0);
    req = 4'b1111; op = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      do_op(0, 1'b1, 1'b0, 1'b0);
      chk("fair_order", 32'(last_gnt), 32'(fair_exp[i]));
    end
    req = '0;

    // Latch stuck low: err is sticky until cleared.
    force0 = 1'b1;
    req = 4'b0010; op = 4'b0010;
    do_op(0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk("err_sticky", 32'(err), 32'd1);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    m_err = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);

    // Clear coincident with a mismatch wins.
    req = 4'b0100; op = 4'b0100;
    do_op(0, 1'b0, 1'b1, 1'b0);
    chk("clr_priority", 32'(err), 32'd0);
    force0 = 1'b0;

    // Pointer is 3 after the grant to 2: wrap order.
    req = 4'b1001; op = 4'b1001;
    do_op(0, 1'b0, 1'b0, 1'b0);
    chk("wrap_first", 32'(last_gnt), 32'b1000);
    do_op(0, 1'b0, 1'b0, 1'b0);
    chk("wrap_second", 32'(last_gnt), 32'b0001);

    // Reset during the second DRIVE cycle.
    req = 4'b0001; op = 4'b0001;
    cyc();
    chk("rst_op_gnt", 32'(gnt), 32'b0001);
    req = '0;
    cyc();
    chk("rst_op_s", 32'(s), 32'd1);
    nrst = 1'b0;
    #1;
    chk("async_s", 32'(s), 32'd0);
    chk("async_r", 32'(r), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_gnt", 32'(gnt), 32'd0);
    m_ptr = 0;
    m_err = 1'b0;
    repeat (2) begin
      cyc();
      chk("rst_no_done", 32'(done), 32'd0);
      chk("rst_no_busy", 32'(busy), 32'd0);
    end
    req = 4'b0100; op = 4'b0000;
    nrst = 1'b1;
    do_op(1, 1'b0, 1'b0, 1'b0);
    chk("post_rst_gnt", 32'(last_gnt), 32'b0100);

    // Random request mixes.
    for (int rnd = 0; rnd < 40; rnd++) begin
      force0 = ($urandom_range(0, 3) == 0);
      req = NREQ'($urandom_range(1, 15));
      op  = NREQ'($urandom);
      while (req != '0) begin
        do_op(0, 1'b0, 1'b0, 1'b1);
        if ($urandom_range(0, 3) == 0) req = req & NREQ'($urandom);
      end
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      m_err = 1'b0;
      chk("rnd_clr", 32'(err), 32'd0);
      chk("rnd_idle", 32'(busy), 32'd0);
      force0 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
